// File: rtl/periph_bus_pkg.sv
// Shared types for the local peripheral port sequencer: FSM states, bus
// owner encoding and the strobe counter width.
package periph_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE_H,
    ST_DONE_B
  } state_t;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_BOOT = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/periph_rr_arb2.sv
// Two-requester round-robin grant. On a tie the requester not granted last
// wins; the last-grant register only moves when a grant is issued.
module periph_rr_arb2
  import periph_bus_pkg::*;
(
  input  logic CLK,
  input  logic RESET_n,
  input  logic en,
  input  logic req_host,
  input  logic req_boot,
  output logic gnt,
  output logic gnt_host
);

  owner_t last_reg;

  always_comb begin
    gnt = en && (req_host || req_boot);
    if (req_host && req_boot)
      gnt_host = (last_reg == OWN_BOOT);
    else
      gnt_host = req_host;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n)
      last_reg <= OWN_BOOT;
    else if (gnt)
      last_reg <= gnt_host ? OWN_HOST : OWN_BOOT;
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the 8-bit local peripheral port between the Zorro III slave path and
// the boot loader, sequencing SETUP / STROBE / HOLD with registered strobes.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       host_sel,
  input  logic       FCS_n,
  input  logic       host_read,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout,
  output logic       host_dtack,
  input  logic       boot_req,
  input  logic       boot_read,
  input  logic [7:0] boot_din,
  output logic [7:0] boot_dout,
  output logic       boot_ack,
  output logic       dev_cs_n,
  output logic       dev_rd_n,
  output logic       dev_wr_n,
  output logic [7:0] dev_dout,
  input  logic [7:0] dev_din,
  output logic       dev_oe,
  output logic       busy
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_wait
      $error("periph_bus_arbiter: WAIT_CYCLES must be within 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_reg;
  owner_t           owner_reg;
  logic             pend_reg;
  logic             read_reg;
  logic [7:0]       wdata_reg;
  logic [7:0]       rdata_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             abort_reg;
  logic             armed_reg;

  logic host_req;
  logic arb_en;
  logic gnt;
  logic gnt_host;

  // The host must release FCS_n between grants, otherwise a strobe still held
  // low after DTACK would immediately start a second device cycle.
  assign host_req = host_sel && !FCS_n && armed_reg;
  assign arb_en   = (state_reg == ST_IDLE) && !pend_reg;

  periph_rr_arb2 u_arb (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .en       (arb_en),
    .req_host (host_req),
    .req_boot (boot_req),
    .gnt      (gnt),
    .gnt_host (gnt_host)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_BOOT;
      pend_reg   <= 1'b0;
      read_reg   <= 1'b1;
      wdata_reg  <= 8'h00;
      rdata_reg  <= 8'hFF;
      cnt_reg    <= '0;
      abort_reg  <= 1'b0;
      armed_reg  <= 1'b1;
      host_dout  <= 8'hFF;
      boot_dout  <= 8'hFF;
      host_dtack <= 1'b0;
      boot_ack   <= 1'b0;
      busy       <= 1'b0;
      dev_cs_n   <= 1'b1;
      dev_rd_n   <= 1'b1;
      dev_wr_n   <= 1'b1;
      dev_dout   <= 8'h00;
      dev_oe     <= 1'b0;
    end else begin
      boot_ack <= 1'b0;

      if (FCS_n)
        armed_reg <= 1'b1;
      else if (gnt && gnt_host)
        armed_reg <= 1'b0;

      // A host strobe released mid-cycle turns the access into an abort; the
      // device cycle still runs to completion so the peripheral sees full timing.
      if (owner_reg == OWN_HOST && FCS_n && (pend_reg || state_reg != ST_IDLE))
        abort_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (pend_reg) begin
            pend_reg  <= 1'b0;
            state_reg <= ST_SETUP;
            busy      <= 1'b1;
            dev_cs_n  <= 1'b0;
            if (!read_reg) begin
              dev_oe   <= 1'b1;
              dev_dout <= wdata_reg;
            end
          end else if (gnt) begin
            pend_reg  <= 1'b1;
            owner_reg <= gnt_host ? OWN_HOST : OWN_BOOT;
            read_reg  <= gnt_host ? host_read : boot_read;
            wdata_reg <= gnt_host ? host_din : boot_din;
            abort_reg <= 1'b0;
          end
        end

        ST_SETUP: begin
          state_reg <= ST_STROBE;
          cnt_reg   <= CNT_INIT;
          dev_rd_n  <= !read_reg;
          dev_wr_n  <= read_reg;
        end

        ST_STROBE: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_HOLD;
            dev_rd_n  <= 1'b1;
            dev_wr_n  <= 1'b1;
            if (read_reg)
              rdata_reg <= dev_din;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_HOLD: begin
          dev_cs_n <= 1'b1;
          dev_oe   <= 1'b0;
          if (owner_reg == OWN_BOOT) begin
            state_reg <= ST_DONE_B;
            boot_ack  <= 1'b1;
            if (read_reg)
              boot_dout <= rdata_reg;
          end else if (abort_reg || FCS_n) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            state_reg  <= ST_DONE_H;
            host_dtack <= 1'b1;
            if (read_reg)
              host_dout <= rdata_reg;
          end
        end

        ST_DONE_H: begin
          if (FCS_n) begin
            state_reg  <= ST_IDLE;
            host_dtack <= 1'b0;
            busy       <= 1'b0;
          end
        end

        ST_DONE_B: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: host/boot reads and writes, ties,
// host abort, asynchronous reset mid-strobe and FCS_n re-arm behaviour.
module tb_periph_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       host_sel = 1'b0;
  logic       FCS_n = 1'b1;
  logic       host_read = 1'b1;
  logic [7:0] host_din = 8'h00;
  logic [7:0] host_dout;
  logic       host_dtack;
  logic       boot_req = 1'b0;
  logic       boot_read = 1'b1;
  logic [7:0] boot_din = 8'h00;
  logic [7:0] boot_dout;
  logic       boot_ack;
  logic       dev_cs_n;
  logic       dev_rd_n;
  logic       dev_wr_n;
  logic [7:0] dev_dout;
  logic [7:0] dev_din = 8'h00;
  logic       dev_oe;
  logic       busy;

  int chk_cnt = 0;
  int pass_cnt = 0;

  int edge_idx, rd_lo, wr_lo, cs_lo, oe_hi, dout_bad, ack_cnt;
  int dt_edge, ack_edge, busy_last;
  logic [7:0] exp_wdata;

  periph_bus_arbiter #(.WAIT_CYCLES(2)) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .host_sel   (host_sel),
    .FCS_n      (FCS_n),
    .host_read  (host_read),
    .host_din   (host_din),
    .host_dout  (host_dout),
    .host_dtack (host_dtack),
    .boot_req   (boot_req),
    .boot_read  (boot_read),
    .boot_din   (boot_din),
    .boot_dout  (boot_dout),
    .boot_ack   (boot_ack),
    .dev_cs_n   (dev_cs_n),
    .dev_rd_n   (dev_rd_n),
    .dev_wr_n   (dev_wr_n),
    .dev_dout   (dev_dout),
    .dev_din    (dev_din),
    .dev_oe     (dev_oe),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    edge_idx = 0; rd_lo = 0; wr_lo = 0; cs_lo = 0; oe_hi = 0; dout_bad = 0;
    ack_cnt = 0; dt_edge = -1; ack_edge = -1; busy_last = -1;
  endtask

  // Step n rising edges (numbered from 0 after clr) and sample each on the
  // following falling edge; boot_req is dropped once its ack is seen.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!dev_rd_n) rd_lo++;
      if (!dev_wr_n) wr_lo++;
      if (!dev_cs_n) cs_lo++;
      if (dev_oe) begin
        oe_hi++;
        if (dev_dout !== exp_wdata) dout_bad++;
      end
      if (host_dtack && dt_edge < 0) dt_edge = edge_idx;
      if (busy) busy_last = edge_idx;
      if (boot_ack) begin
        ack_cnt++;
        if (ack_edge < 0) ack_edge = edge_idx;
        boot_req = 1'b0;
      end
      edge_idx++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_n = 1'b0;
    host_sel = 1'b0; FCS_n = 1'b1; boot_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
  endtask

  task automatic host_release();
    host_sel = 1'b0;
    FCS_n = 1'b1;
  endtask

  initial begin
    exp_wdata = 8'h00;
    clr();
    do_reset();

    chk("rst_dtack", 32'(host_dtack), 32'd0);
    chk("rst_ack", 32'(boot_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({dev_cs_n, dev_rd_n, dev_wr_n, dev_oe}), 32'b1110);
    chk("rst_dev_dout", 32'(dev_dout), 32'h00);
    chk("rst_host_dout", 32'(host_dout), 32'hFF);
    chk("rst_boot_dout", 32'(boot_dout), 32'hFF);

    // Host read of 0xA5
    dev_din = 8'hA5; host_read = 1'b1; host_sel = 1'b1; FCS_n = 1'b0;
    clr(); observe(8);
    $display("host read: rd_lo=%0d cs_lo=%0d dtack@%0d dout=%h", rd_lo, cs_lo, dt_edge, host_dout);
    chk("hrd_rd_width", rd_lo, 2);
    chk("hrd_cs_width", cs_lo, 4);
    chk("hrd_dtack_edge", dt_edge, 5);
    chk("hrd_dout", 32'(host_dout), 32'hA5);
    chk("hrd_dtack_held", 32'(host_dtack), 32'd1);
    host_release();
    @(posedge CLK); @(negedge CLK);
    chk("hrd_dtack_fall", 32'({host_dtack, busy}), 32'b00);

    // Boot write of 0x3C
    exp_wdata = 8'h3C; boot_din = 8'h3C; boot_read = 1'b0; boot_req = 1'b1;
    clr(); observe(8);
    $display("boot write: wr_lo=%0d oe_hi=%0d ack@%0d acks=%0d", wr_lo, oe_hi, ack_edge, ack_cnt);
    chk("bwr_wr_width", wr_lo, 2);
    chk("bwr_oe_span", oe_hi, 4);
    chk("bwr_dout", dout_bad, 0);
    chk("bwr_ack_edge", ack_edge, 5);
    chk("bwr_ack_once", ack_cnt, 1);

    // Boot read of 0x5A; host data must stay untouched
    dev_din = 8'h5A; boot_read = 1'b1; boot_req = 1'b1;
    clr(); observe(8);
    $display("boot read: ack@%0d boot_dout=%h host_dout=%h", ack_edge, boot_dout, host_dout);
    chk("brd_ack_edge", ack_edge, 5);
    chk("brd_dout", 32'(boot_dout), 32'h5A);
    chk("brd_host_keep", 32'(host_dout), 32'hA5);

    // Host abort during STROBE
    dev_din = 8'h77; host_read = 1'b1; host_sel = 1'b1; FCS_n = 1'b0;
    clr(); observe(3);
    host_release();
    observe(5);
    $display("host abort: rd_lo=%0d dtack@%0d busy_last=%0d host_dout=%h", rd_lo, dt_edge, busy_last, host_dout);
    chk("abt_rd_width", rd_lo, 2);
    chk("abt_no_dtack", dt_edge, -1);
    chk("abt_busy_fall", busy_last, 4);
    chk("abt_dout_keep", 32'(host_dout), 32'hA5);

    // Asynchronous reset in the middle of a boot write strobe
    exp_wdata = 8'h96; boot_din = 8'h96; boot_read = 1'b0; boot_req = 1'b1;
    clr(); observe(3);
    chk("rmid_in_strobe", 32'(dev_wr_n), 32'd0);
    #2 RESET_n = 1'b0;
    boot_req = 1'b0;
    #1;
    $display("reset mid-strobe: cs_n=%b rd_n=%b wr_n=%b oe=%b", dev_cs_n, dev_rd_n, dev_wr_n, dev_oe);
    chk("rmid_release", 32'({dev_cs_n, dev_rd_n, dev_wr_n, dev_oe, busy}), 32'b11100);
    @(negedge CLK); @(negedge CLK);
    RESET_n = 1'b1;
    clr(); observe(4);
    chk("rmid_no_ack", ack_cnt, 0);
    exp_wdata = 8'hC3; boot_din = 8'hC3; boot_req = 1'b1;
    clr(); observe(8);
    $display("post-reset boot write: wr_lo=%0d ack@%0d", wr_lo, ack_edge);
    chk("rmid_recover_ack", ack_edge, 5);
    chk("rmid_recover_wr", wr_lo, 2);
    chk("rmid_recover_dout", dout_bad, 0);

    // Ties: host wins the first after reset, boot follows on FCS_n release
    do_reset();
    dev_din = 8'h11; host_read = 1'b1; boot_read = 1'b1;
    host_sel = 1'b1; FCS_n = 1'b0; boot_req = 1'b1;
    clr(); observe(7);
    $display("tie1: dtack@%0d acks=%0d", dt_edge, ack_cnt);
    chk("tie1_host_wins", dt_edge, 5);
    chk("tie1_boot_waits", ack_cnt, 0);
    host_release();
    clr(); observe(8);
    $display("tie1 follow-up: boot ack@%0d boot_dout=%h", ack_edge, boot_dout);
    chk("tie1_boot_next", ack_edge, 6);
    chk("tie1_boot_dout", 32'(boot_dout), 32'h11);

    // Last grant was boot, so host wins this tie
    host_sel = 1'b1; FCS_n = 1'b0; boot_req = 1'b1;
    clr(); observe(7);
    $display("tie2: dtack@%0d acks=%0d", dt_edge, ack_cnt);
    chk("tie2_host_wins", dt_edge, 5);
    chk("tie2_boot_waits", ack_cnt, 0);
    host_release();
    clr(); observe(8);
    chk("tie2_boot_next", ack_edge, 6);

    // Lone host grant, then a tie that must go to boot
    host_sel = 1'b1; FCS_n = 1'b0;
    clr(); observe(7);
    chk("lone_host", dt_edge, 5);
    host_release();
    observe(2);
    host_sel = 1'b1; FCS_n = 1'b0; boot_req = 1'b1;
    clr(); observe(7);
    $display("tie3: ack@%0d dtack@%0d", ack_edge, dt_edge);
    chk("tie3_boot_wins", ack_edge, 5);
    chk("tie3_host_waits", dt_edge, -1);
    clr(); observe(8);
    chk("tie3_host_next", dt_edge, 5);
    host_release();
    observe(2);

    // FCS_n held low after DTACK: no second device cycle until re-armed
    dev_din = 8'h3E; host_read = 1'b1; host_sel = 1'b1; FCS_n = 1'b0;
    clr(); observe(12);
    $display("hold FCS_n: cs_lo=%0d dtack@%0d dtack=%b", cs_lo, dt_edge, host_dtack);
    chk("rearm_one_cycle", cs_lo, 4);
    chk("rearm_dtack_edge", dt_edge, 5);
    chk("rearm_dtack_held", 32'(host_dtack), 32'd1);
    FCS_n = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("rearm_dtack_fall", 32'(host_dtack), 32'd0);
    FCS_n = 1'b0;
    clr(); observe(7);
    $display("re-armed host: cs_lo=%0d dtack@%0d", cs_lo, dt_edge);
    chk("rearm_second", dt_edge, 5);
    chk("rearm_second_cs", cs_lo, 4);
    host_release();
    observe(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Sequences and shares the card's 8-bit local peripheral port between two requesters:
- the Zorro III slave path (host accesses framed by FCS_n);
- the internal boot loader (req/ack), which reads the DIP/ID byte into shadow logic after reset.

It generates chip-select, read and write strobes with programmable width, captures read data, returns host DTACK held until FCS_n rises, and returns a one-cycle ack to the loader.

## Interface
Parameters:
- WAIT_CYCLES, 2: strobe width in CLK cycles; legal range 1..15.

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous, active-low reset
- host_sel  in  1  address decode hit, already qualified by slave_cycle and configured
- FCS_n  in  1  Zorro full-cycle strobe, active low
- host_read  in  1  1 = read, 0 = write
- host_din  in  8  host write data
- host_dout  out  8  host read data, registered
- host_dtack  out  1  host transfer acknowledge
- boot_req  in  1  loader request level; held until boot_ack
- boot_read  in  1  loader direction
- boot_din  in  8  loader write data
- boot_dout  out  8  loader read data, registered
- boot_ack  out  1  one-cycle completion pulse
- dev_cs_n  out  1  device chip select, active low
- dev_rd_n  out  1  device read strobe, active low
- dev_wr_n  out  1  device write strobe, active low
- dev_dout  out  8  device write data
- dev_din  in  8  device read data
- dev_oe  out  1  enable for driving dev_dout onto the device bus
- busy  out  1  high in any state other than IDLE

## Operation
- Host request condition: host_sel && !FCS_n. Boot request condition: boot_req.
- Arbitration happens only in IDLE and is round-robin.
  - A lone request wins.
  - If both requests arrive on the same edge, the requester not granted last wins.
  - The last-grant flag resets to "boot", so the host wins the first tie.
- The granted requester's direction and write data are latched at grant and held for the whole cycle.
- Outputs per state:
  - IDLE: all device strobes high, dev_oe = 0.
  - SETUP (1 cycle): dev_cs_n = 0. On a write, dev_dout is driven and dev_oe = 1.
  - STROBE (WAIT_CYCLES cycles): dev_rd_n = 0 (read) or dev_wr_n = 0 (write). On a read, dev_din is registered on the last STROBE edge into host_dout or boot_dout, selected by the owner.
  - HOLD (1 cycle): strobes high, dev_cs_n = 0, dev_oe held for writes.
- Transitions out of HOLD:
  - Host owner goes to DONE_H. host_dtack = 1, held until FCS_n is sampled high; then dtack = 0 and state returns to IDLE.
  - Boot owner goes to DONE_B. boot_ack = 1 for exactly one cycle; then IDLE.
- Host abort: if FCS_n rises before DONE_H, the device cycle still completes with full strobe width and no truncation. The block then goes straight to IDLE, with no dtack and host_dout unchanged.
- A request arriving while busy waits. It is evaluated in IDLE on the edge after DONE_H or DONE_B exits.
- A host request still present in IDLE after a DONE_H exit must not re-trigger. The host must see FCS_n high at least once between grants; track this with an armed flag.
- Strobe counter width is 4 bits and counts down from WAIT_CYCLES-1. Behaviour for WAIT_CYCLES outside 1..15 is undefined; flag it with an elaboration-time check.

## Timing
- Request sampled at edge 0:
  - SETUP from edge 1.
  - STROBE from edge 2 to edge WAIT_CYCLES+1.
  - HOLD at edge WAIT_CYCLES+2.
  - host_dtack or boot_ack rises at edge WAIT_CYCLES+3.
  - Default WAIT_CYCLES = 2 gives acknowledge at edge 5.
- host_dtack falls on the first edge at which FCS_n is sampled high. The earliest next grant is on the following edge.
- Read data is valid on host_dout/boot_dout from the acknowledge edge and stays stable until the same requester's next read capture.
- Reset values: host_dtack = 0, boot_ack = 0, busy = 0, dev_cs_n = dev_rd_n = dev_wr_n = 1, dev_oe = 0, dev_dout = 8'h00, host_dout = 8'hFF, boot_dout = 8'hFF, last-grant = boot, armed = 1.
- Asserting reset mid-cycle releases all strobes immediately (asynchronous). No acknowledge is issued.

## Structure
- Shared package `periph_bus_pkg`:
  - state encoding: IDLE, SETUP, STROBE, HOLD, DONE_H, DONE_B;
  - owner enum: HOST, BOOT;
  - strobe counter width constant.
- One sub-module, `periph_rr_arb2`: a two-requester round-robin grant with a last-grant register, updated only on grant. The state machine and datapath stay in the top module.

## Test plan
- Host read, WAIT_CYCLES=2, dev_din=8'hA5: dev_rd_n low for exactly 2 cycles, host_dtack rises at edge 5, host_dout = 8'hA5, dtack held until FCS_n high.
- Boot write 8'h3C: dev_wr_n low for 2 cycles with dev_dout = 8'h3C and dev_oe = 1 from SETUP through HOLD; one-cycle boot_ack at edge 5.
- Simultaneous host and boot requests after reset: host granted first, boot served immediately after the host's FCS_n release; a second tie goes to the other requester.
- Host abort: FCS_n deasserted during STROBE. Full strobe width is kept, no dtack, host_dout is unchanged, and busy falls after HOLD.
- RESET_n pulsed low mid-STROBE: all strobes return high asynchronously; after release, a new boot request completes normally.
- FCS_n held low after dtack with host_sel still high: no second device cycle until FCS_n goes high and low again.
